// File: rtl/led_scan_ctrl_if.sv
// Scan-controller signal bundle: run request in, AL422 read control,
// receiver control and HUB75 panel drive out.
interface led_scan_ctrl_if #(
    parameter int ROW_W = 4
);
    logic             enable;
    logic             fifo_rrst_n;
    logic             fifo_re_n;
    logic             rx_nrst;
    logic [5:0]       pwm_value;
    logic [ROW_W-1:0] row_addr;
    logic             led_lat;
    logic             led_oe_n;
    logic             busy;
    logic             frame_done;

    modport master (
        input  enable,
        output fifo_rrst_n,
        output fifo_re_n,
        output rx_nrst,
        output pwm_value,
        output row_addr,
        output led_lat,
        output led_oe_n,
        output busy,
        output frame_done
    );

    modport slave (
        output enable,
        input  fifo_rrst_n,
        input  fifo_re_n,
        input  rx_nrst,
        input  pwm_value,
        input  row_addr,
        input  led_lat,
        input  led_oe_n,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// HUB75 scan sequencer: re-reads the AL422 frame once per PWM pass, one line
// at a time, and drives row address, latch and output-enable for the panel.
module led_scan_ctrl #(
    parameter int PIXELS    = 64,
    parameter int ROWS      = 16,
    parameter int ROW_W     = 4,
    parameter int RRST_CYC  = 2,
    parameter int BLANK_CYC = 4
) (
    input  logic            in_clk,
    input  logic            in_rst,
    led_scan_ctrl_if.master scan
);

    localparam int SHIFT_CYC = 2 * PIXELS + 2;
    localparam int CNT_MAX0  = (SHIFT_CYC > RRST_CYC) ? SHIFT_CYC : RRST_CYC;
    localparam int CNT_MAX   = (CNT_MAX0 > BLANK_CYC) ? CNT_MAX0 : BLANK_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RRST_LAST  = CNT_W'(RRST_CYC - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);
    localparam logic [CNT_W-1:0] READ_END   = CNT_W'(2 * PIXELS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [ROW_W-1:0] LINE_ZERO  = {ROW_W{1'b0}};
    localparam logic [ROW_W-1:0] LINE_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0] LINE_LAST  = ROW_W'(ROWS - 1);
    localparam logic [5:0]       PWM_LAST   = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FRST  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_BLK0  = 3'd4,
        ST_LAT   = 3'd5,
        ST_BLK1  = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [ROW_W-1:0] line_r;
    logic [ROW_W-1:0] line_s;
    logic [5:0]       pwm_r;
    logic [5:0]       pwm_s;
    logic             lit_r;
    logic             lit_s;
    logic             frame_end_s;

    logic             rrst_n_r;
    logic             re_n_r;
    logic             rx_nrst_r;
    logic [ROW_W-1:0] row_r;
    logic             lat_r;
    logic             oe_n_r;
    logic             busy_r;
    logic             frame_done_r;

    // Next-state and counter update; END is folded into the last BLK1 cycle.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        line_s      = line_r;
        pwm_s       = pwm_r;
        lit_s       = lit_r;
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                lit_s = 1'b0;
                if (scan.enable) begin
                    state_s = ST_FRST;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FRST: begin
                if (cnt_r == RRST_LAST) begin
                    state_s = ST_SYNC;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SYNC: begin
                state_s = ST_SHIFT;
                cnt_s   = CNT_ZERO;
            end
            ST_SHIFT: begin
                if (cnt_r == SHIFT_LAST) begin
                    state_s = ST_BLK0;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_BLK0: begin
                state_s = ST_LAT;
            end
            ST_LAT: begin
                state_s = ST_BLK1;
                cnt_s   = CNT_ZERO;
                lit_s   = 1'b1;
            end
            ST_BLK1: begin
                if (cnt_r == BLANK_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (line_r != LINE_LAST) begin
                        line_s  = line_r + LINE_ONE;
                        state_s = ST_SYNC;
                    end else if (pwm_r != PWM_LAST) begin
                        line_s  = LINE_ZERO;
                        pwm_s   = pwm_r + 6'd1;
                        state_s = ST_FRST;
                    end else begin
                        line_s      = LINE_ZERO;
                        pwm_s       = 6'd0;
                        frame_end_s = 1'b1;
                        state_s     = scan.enable ? ST_FRST : ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                line_s  = LINE_ZERO;
                pwm_s   = 6'd0;
                lit_s   = 1'b0;
            end
        endcase
    end

    // State register plus outputs decoded from the next state, so each output
    // already shows its state's value in the first cycle of that state.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            line_r       <= LINE_ZERO;
            pwm_r        <= 6'd0;
            lit_r        <= 1'b0;
            rrst_n_r     <= 1'b1;
            re_n_r       <= 1'b1;
            rx_nrst_r    <= 1'b0;
            row_r        <= LINE_ZERO;
            lat_r        <= 1'b0;
            oe_n_r       <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            line_r       <= line_s;
            pwm_r        <= pwm_s;
            lit_r        <= lit_s;
            rrst_n_r     <= (state_s != ST_FRST);
            re_n_r       <= ~((state_s == ST_SHIFT) && (cnt_s < READ_END));
            rx_nrst_r    <= ~((state_s == ST_IDLE) || (state_s == ST_FRST) ||
                              (state_s == ST_SYNC));
            lat_r        <= (state_s == ST_LAT);
            oe_n_r       <= ~(((state_s == ST_SYNC) || (state_s == ST_SHIFT)) && lit_s);
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= frame_end_s;
            if (state_s == ST_LAT) begin
                row_r <= line_r;
            end else begin
                row_r <= row_r;
            end
        end
    end

    assign scan.fifo_rrst_n = rrst_n_r;
    assign scan.fifo_re_n   = re_n_r;
    assign scan.rx_nrst     = rx_nrst_r;
    assign scan.pwm_value   = pwm_r;
    assign scan.row_addr    = row_r;
    assign scan.led_lat     = lat_r;
    assign scan.led_oe_n    = oe_n_r;
    assign scan.busy        = busy_r;
    assign scan.frame_done  = frame_done_r;

endmodule
